// File: rtl/query_loader.sv
// rtl/query_loader.sv - serial query frame parser that launches a k-NN search
module query_loader #(
  parameter int DIM     = 8,
  parameter int MAX_K   = 5,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  input  logic        search_ready_in,
  output logic [31:0] vertex_id_out,
  output logic [31:0] query_out [DIM],
  output logic [15:0] k_out,
  output logic        valid_out,
  output logic        busy_out,
  output logic        error_out,
  output logic [2:0]  state_out
);

  localparam int QBYTES = DIM * 4;
  localparam int CW     = $clog2(QBYTES + 1);
  localparam int GW     = $clog2(TIMEOUT + 1);
  localparam int EW     = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    QUERY  = 3'd2,
    CHECK  = 3'd3,
    LAUNCH = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap;
  // Little-endian header: vertex id in [31:0], k in [47:32] once all 6 bytes are in.
  logic [47:0]   hdr_stage;
  logic [31:0]   q_stage [DIM];
  logic [EW-1:0] elem_idx;
  logic          gap_expired;
  logic [15:0]   k_stage;

  assign elem_idx    = EW'(cnt >> 2);
  assign gap_expired = (gap == GW'(TIMEOUT - 1));
  assign k_stage     = hdr_stage[47:32];
  assign busy_out    = (state != IDLE);
  assign state_out   = state;

  // Frame parser FSM; staging registers stay separate from the held launch outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      cnt           <= '0;
      gap           <= '0;
      hdr_stage     <= '0;
      vertex_id_out <= '0;
      k_out         <= '0;
      valid_out     <= 1'b0;
      error_out     <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        q_stage[i]   <= '0;
        query_out[i] <= '0;
      end
    end else begin
      valid_out <= 1'b0;
      error_out <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          gap <= '0;
          if (byte_valid_in && (byte_in == 8'hA5)) begin
            state <= HDR;
          end
        end
        HDR: begin
          if (byte_valid_in) begin
            gap       <= '0;
            hdr_stage <= {byte_in, hdr_stage[47:8]};
            if (cnt == CW'(5)) begin
              cnt   <= '0;
              state <= QUERY;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (gap_expired) begin
            error_out <= 1'b1;
            gap       <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            gap <= gap + GW'(1);
          end
        end
        QUERY: begin
          if (byte_valid_in) begin
            gap <= '0;
            q_stage[elem_idx][{cnt[1:0], 3'b000} +: 8] <= byte_in;
            if (cnt == CW'(QBYTES - 1)) begin
              cnt   <= '0;
              state <= CHECK;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (gap_expired) begin
            error_out <= 1'b1;
            gap       <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            gap <= gap + GW'(1);
          end
        end
        CHECK: begin
          if ((k_stage == 16'd0) || (k_stage > 16'(MAX_K))) begin
            error_out <= 1'b1;
            state     <= IDLE;
          end else begin
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (search_ready_in) begin
            valid_out     <= 1'b1;
            vertex_id_out <= hdr_stage[31:0];
            k_out         <= k_stage;
            for (int i = 0; i < DIM; i++) begin
              query_out[i] <= q_stage[i];
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_query_loader.sv
// tb/tb_query_loader.sv - randomized self-checking bench for query_loader
module tb_query_loader;

  localparam int DIM     = 8;
  localparam int MAX_K   = 5;
  localparam int TIMEOUT = 100;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic        search_ready_in;
  logic [31:0] vertex_id_out;
  logic [31:0] query_out [DIM];
  logic [15:0] k_out;
  logic        valid_out;
  logic        busy_out;
  logic        error_out;
  logic [2:0]  state_out;

  always #5 clk_in = ~clk_in;

  query_loader #(.DIM(DIM), .MAX_K(MAX_K), .TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .search_ready_in(search_ready_in), .vertex_id_out(vertex_id_out), .query_out(query_out),
    .k_out(k_out), .valid_out(valid_out), .busy_out(busy_out), .error_out(error_out),
    .state_out(state_out)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int error_cnt = 0;
  int valid_edge = -1;
  int error_edge = -1;
  int last_byte_edge = 0;

  // Reference model: frame fields and the outputs a correct loader must be holding.
  logic [31:0] f_vertex;
  logic [15:0] f_k;
  logic [31:0] f_query [DIM];
  logic [31:0] exp_vertex;
  logic [15:0] exp_k;
  logic [31:0] exp_query [DIM];
  logic [7:0]  frame_q [$];

  // Edge counter and pulse monitor, sampled shortly after each rising edge.
  always begin
    @(posedge clk_in);
    #2;
    cyc = cyc + 1;
    if (valid_out === 1'b1) begin valid_cnt++; valid_edge = cyc; end
    if (error_out === 1'b1) begin error_cnt++; error_edge = cyc; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end

  function automatic logic [7:0] rand_byte();
    return ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
  endfunction

  task automatic randomize_fields(input logic [15:0] k);
    f_vertex = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
    f_k = k;
    for (int e = 0; e < DIM; e++) f_query[e] = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
  endtask

  task automatic make_frame();
    frame_q = {};
    frame_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) frame_q.push_back(f_vertex[8*i +: 8]);
    for (int i = 0; i < 2; i++) frame_q.push_back(f_k[8*i +: 8]);
    for (int e = 0; e < DIM; e++)
      for (int b = 0; b < 4; b++) frame_q.push_back(f_query[e][8*b +: 8]);
  endtask

  function automatic bit model_launches();
    return (f_k >= 16'd1) && (f_k <= 16'(MAX_K));
  endfunction

  task automatic model_commit();
    if (model_launches()) begin
      exp_vertex = f_vertex;
      exp_k = f_k;
      for (int e = 0; e < DIM; e++) exp_query[e] = f_query[e];
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_in = b;
    byte_valid_in = 1'b1;
    @(negedge clk_in);
    byte_valid_in = 1'b0;
    last_byte_edge = cyc;
    repeat (gap) @(negedge clk_in);
  endtask

  task automatic send_frame(input int max_gap, input int nbytes);
    for (int i = 0; i < nbytes; i++)
      send_byte(frame_q[i], (i == nbytes - 1) ? 0 : int'($urandom_range(0, max_gap)));
  endtask

  task automatic run_frame(input int max_gap, output int dv, output int de, output int lat);
    int v0, e0;
    v0 = valid_cnt;
    e0 = error_cnt;
    send_frame(max_gap, frame_q.size());
    for (int i = 0; i < 10 && valid_cnt == v0 && error_cnt == e0; i++) @(negedge clk_in);
    repeat (3) @(negedge clk_in);
    dv = valid_cnt - v0;
    de = error_cnt - e0;
    lat = (dv > 0) ? valid_edge - last_byte_edge : (de > 0) ? error_edge - last_byte_edge : -1;
  endtask

  task automatic test_reset();
    int qbad;
    rst_in = 1'b1; byte_in = 8'h00; byte_valid_in = 1'b0; search_ready_in = 1'b1;
    repeat (3) @(negedge clk_in);
    exp_vertex = '0; exp_k = '0;
    for (int e = 0; e < DIM; e++) exp_query[e] = '0;
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_out); end
    checks++; if ({valid_out, error_out, busy_out} !== 3'b000) begin errors++; $display("FAIL reset_flags: valid/error/busy got %b want 000", {valid_out, error_out, busy_out}); end
    checks++; if (vertex_id_out !== 32'd0 || k_out !== 16'd0) begin errors++; $display("FAIL reset_fields: vertex %h k %h want 0", vertex_id_out, k_out); end
    qbad = 0; for (int e = 0; e < DIM; e++) if (query_out[e] !== 32'd0) qbad++;
    checks++; if (qbad != 0) begin errors++; $display("FAIL reset_query: %0d elements nonzero, want 0", qbad); end
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_basic();
    int dv, de, lat, qbad;
    f_vertex = 32'd1; f_k = 16'd4;
    f_query = '{32'd5, 32'd7, 32'd1, 32'd1, 32'd5, 32'd7, 32'd1, 32'd1};
    make_frame();
    run_frame(0, dv, de, lat);
    model_commit();
    checks++; if (dv != 1 || de != 0) begin errors++; $display("FAIL basic_pulses: valid %0d error %0d want 1 0", dv, de); end
    checks++; if (lat != 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", lat); end
    checks++; if (vertex_id_out !== exp_vertex || k_out !== exp_k) begin errors++; $display("FAIL basic_fields: vertex %h k %h want %h %h", vertex_id_out, k_out, exp_vertex, exp_k); end
    qbad = 0; for (int e = 0; e < DIM; e++) if (query_out[e] !== exp_query[e]) qbad++;
    checks++; if (qbad != 0) begin errors++; $display("FAIL basic_query: %0d elements differ, q0 got %h want %h", qbad, query_out[0], exp_query[0]); end
    checks++; if (state_out !== 3'd0 || busy_out !== 1'b0) begin errors++; $display("FAIL basic_idle: state %0d busy %b want 0 0", state_out, busy_out); end
  endtask

  task automatic test_leading_garbage();
    int dv, de, lat, qbad;
    send_byte(8'h00, 1); send_byte(8'hFF, 1); send_byte(8'h3C, 1);
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL garbage_idle: state %0d want 0", state_out); end
    randomize_fields(16'($urandom_range(1, MAX_K)));
    make_frame();
    run_frame(2, dv, de, lat);
    model_commit();
    checks++; if (dv != 1 || de != 0) begin errors++; $display("FAIL garbage_pulses: valid %0d error %0d want 1 0", dv, de); end
    checks++; if (vertex_id_out !== exp_vertex || k_out !== exp_k) begin errors++; $display("FAIL garbage_fields: vertex %h k %h want %h %h", vertex_id_out, k_out, exp_vertex, exp_k); end
    qbad = 0; for (int e = 0; e < DIM; e++) if (query_out[e] !== exp_query[e]) qbad++;
    checks++; if (qbad != 0) begin errors++; $display("FAIL garbage_query: %0d elements differ", qbad); end
  endtask

  task automatic test_bad_k();
    int dv, de, lat, qbad;
    logic [15:0] bad_ks [2];
    bad_ks = '{16'd0, 16'd6};
    for (int t = 0; t < 2; t++) begin
      randomize_fields(bad_ks[t]);
      make_frame();
      run_frame(1, dv, de, lat);
      model_commit();
      checks++; if (dv != 0 || de != 1) begin errors++; $display("FAIL badk_pulses k=%0d: valid %0d error %0d want 0 1", bad_ks[t], dv, de); end
      checks++; if (lat != 1) begin errors++; $display("FAIL badk_latency k=%0d: got %0d want 1", bad_ks[t], lat); end
      checks++; if (vertex_id_out !== exp_vertex || k_out !== exp_k) begin errors++; $display("FAIL badk_held k=%0d: vertex %h k %h want %h %h", bad_ks[t], vertex_id_out, k_out, exp_vertex, exp_k); end
      qbad = 0; for (int e = 0; e < DIM; e++) if (query_out[e] !== exp_query[e]) qbad++;
      checks++; if (qbad != 0) begin errors++; $display("FAIL badk_query k=%0d: %0d elements changed", bad_ks[t], qbad); end
    end
  endtask

  task automatic test_random_frames();
    int dv, de, lat, qbad, want_v;
    for (int n = 0; n < 10; n++) begin
      randomize_fields(16'($urandom_range(0, 7)));
      make_frame();
      want_v = model_launches() ? 1 : 0;
      run_frame(3, dv, de, lat);
      model_commit();
      checks++; if (dv != want_v || de != 1 - want_v) begin errors++; $display("FAIL rand%0d_pulses k=%0d: valid %0d error %0d want %0d %0d", n, f_k, dv, de, want_v, 1 - want_v); end
      checks++; if (vertex_id_out !== exp_vertex || k_out !== exp_k) begin errors++; $display("FAIL rand%0d_fields: vertex %h k %h want %h %h", n, vertex_id_out, k_out, exp_vertex, exp_k); end
      qbad = 0; for (int e = 0; e < DIM; e++) if (query_out[e] !== exp_query[e]) qbad++;
      checks++; if (qbad != 0) begin errors++; $display("FAIL rand%0d_query: %0d elements differ", n, qbad); end
    end
  endtask

  task automatic test_timeout();
    int v0, e0, start, dv, de, lat, qbad;
    randomize_fields(16'd3);
    make_frame();
    v0 = valid_cnt; e0 = error_cnt;
    send_frame(0, 1 + 6 + 10);
    start = last_byte_edge;
    for (int i = 0; i < TIMEOUT + 20 && error_cnt == e0; i++) @(negedge clk_in);
    checks++; if (error_cnt - e0 != 1) begin errors++; $display("FAIL timeout_error: pulses %0d want 1", error_cnt - e0); end
    checks++; if (error_edge - start != TIMEOUT) begin errors++; $display("FAIL timeout_gap: got %0d want %0d", error_edge - start, TIMEOUT); end
    checks++; if (state_out !== 3'd0 || busy_out !== 1'b0) begin errors++; $display("FAIL timeout_idle: state %0d busy %b want 0 0", state_out, busy_out); end
    repeat (3) @(negedge clk_in);
    checks++; if (valid_cnt != v0 || error_cnt - e0 != 1) begin errors++; $display("FAIL timeout_extra: valid %0d error %0d want 0 1", valid_cnt - v0, error_cnt - e0); end
    checks++; if (vertex_id_out !== exp_vertex || k_out !== exp_k) begin errors++; $display("FAIL timeout_held: vertex %h k %h want %h %h", vertex_id_out, k_out, exp_vertex, exp_k); end
    randomize_fields(16'($urandom_range(1, MAX_K)));
    make_frame();
    run_frame(2, dv, de, lat);
    model_commit();
    checks++; if (dv != 1 || de != 0) begin errors++; $display("FAIL timeout_next_pulses: valid %0d error %0d want 1 0", dv, de); end
    qbad = 0; for (int e = 0; e < DIM; e++) if (query_out[e] !== exp_query[e]) qbad++;
    checks++; if (qbad != 0 || vertex_id_out !== exp_vertex || k_out !== exp_k) begin errors++; $display("FAIL timeout_next_fields: vertex %h k %h want %h %h, %0d query diffs", vertex_id_out, k_out, exp_vertex, exp_k, qbad); end
  endtask

  task automatic test_backpressure();
    int v0, e0, bad, qbad;
    search_ready_in = 1'b0;
    randomize_fields(16'($urandom_range(1, MAX_K)));
    make_frame();
    v0 = valid_cnt; e0 = error_cnt;
    send_frame(1, frame_q.size());
    byte_in = 8'hA5; byte_valid_in = 1'b1;
    @(negedge clk_in);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (state_out !== 3'd4 || busy_out !== 1'b1 || valid_cnt != v0) bad++;
      byte_valid_in = (i < 8);
      byte_in = (i == 0) ? 8'hA5 : 8'(i);
      @(negedge clk_in);
    end
    byte_valid_in = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d of 50 cycles not in LAUNCH/busy or launched early, state %0d", bad, state_out); end
    search_ready_in = 1'b1;
    for (int i = 0; i < 5 && valid_cnt == v0; i++) @(negedge clk_in);
    model_commit();
    @(negedge clk_in);
    checks++; if (valid_cnt - v0 != 1 || error_cnt != e0) begin errors++; $display("FAIL stall_release: valid %0d error %0d want 1 0", valid_cnt - v0, error_cnt - e0); end
    checks++; if (state_out !== 3'd0 || busy_out !== 1'b0) begin errors++; $display("FAIL stall_idle: state %0d busy %b want 0 0", state_out, busy_out); end
    qbad = 0; for (int e = 0; e < DIM; e++) if (query_out[e] !== exp_query[e]) qbad++;
    checks++; if (qbad != 0 || vertex_id_out !== exp_vertex || k_out !== exp_k) begin errors++; $display("FAIL stall_fields: vertex %h k %h want %h %h, %0d query diffs", vertex_id_out, k_out, exp_vertex, exp_k, qbad); end
  endtask

  task automatic test_reset_midframe();
    int v0, e0, dv, de, lat, qbad;
    randomize_fields(16'd2);
    make_frame();
    v0 = valid_cnt; e0 = error_cnt;
    send_frame(0, 4);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    exp_vertex = '0; exp_k = '0;
    for (int e = 0; e < DIM; e++) exp_query[e] = '0;
    checks++; if (state_out !== 3'd0 || busy_out !== 1'b0) begin errors++; $display("FAIL midrst_state: state %0d busy %b want 0 0", state_out, busy_out); end
    qbad = 0; for (int e = 0; e < DIM; e++) if (query_out[e] !== exp_query[e]) qbad++;
    checks++; if (qbad != 0 || vertex_id_out !== exp_vertex || k_out !== exp_k) begin errors++; $display("FAIL midrst_fields: vertex %h k %h want 0 0, %0d query nonzero", vertex_id_out, k_out, qbad); end
    repeat (3) @(negedge clk_in);
    checks++; if (valid_cnt != v0 || error_cnt != e0) begin errors++; $display("FAIL midrst_pulses: valid %0d error %0d want 0 0", valid_cnt - v0, error_cnt - e0); end
    randomize_fields(16'($urandom_range(1, MAX_K)));
    make_frame();
    run_frame(2, dv, de, lat);
    model_commit();
    checks++; if (dv != 1 || de != 0 || lat != 2) begin errors++; $display("FAIL midrst_next: valid %0d error %0d latency %0d want 1 0 2", dv, de, lat); end
    qbad = 0; for (int e = 0; e < DIM; e++) if (query_out[e] !== exp_query[e]) qbad++;
    checks++; if (qbad != 0 || vertex_id_out !== exp_vertex || k_out !== exp_k) begin errors++; $display("FAIL midrst_next_fields: vertex %h k %h want %h %h, %0d query diffs", vertex_id_out, k_out, exp_vertex, exp_k, qbad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_leading_garbage();
    test_bad_k();
    test_random_frames();
    test_timeout();
    test_backpressure();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
